// File: rtl/response_order_sched.sv
// response_order_sched
//   In-order release scheduler for the response parking lot. Keeps a per-original-ID
//   FIFO of issued UIDs, tracks which UIDs are parked, and walks one response at a
//   time through the park: ALLOCATE -> send on the master channel -> FREE.
//   Same-ID responses leave in issue order; different IDs are served round-robin.
//   Optional: define RESP_SCHED_WATCHDOG_EN to add a timeout on ALLOC/FREE that
//   raises a sticky err_timeout and abandons the stuck response.
module response_order_sched #(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int RESP_WIDTH = 2,
    parameter int ID_WIDTH   = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int QDEPTH     = 4,
    parameter int WD_CYCLES  = 64,
    localparam int UID_W     = $clog2(NUM_ROWS) + $clog2(NUM_COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [UID_W-1:0]      issue_uid,
    input  logic [ID_WIDTH-1:0]   issue_orig_id,
    input  logic                  park_enq_fire,
    input  logic [UID_W-1:0]      park_enq_uid,
    output logic                  alloc_req,
    output logic [UID_W-1:0]      alloc_uid,
    input  logic                  alloc_gnt,
    input  logic [DATA_WIDTH-1:0] park_data,
    input  logic [RESP_WIDTH-1:0] park_resp,
    input  logic [ID_WIDTH-1:0]   park_orig_id,
    input  logic [TAG_WIDTH-1:0]  park_tagid,
    output logic                  free_req,
    output logic [UID_W-1:0]      free_uid,
    input  logic                  free_ack,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [RESP_WIDTH-1:0] m_resp,
    output logic [ID_WIDTH-1:0]   m_id,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  err_timeout
);

    localparam int NUM_IDS  = 2 ** ID_WIDTH;
    localparam int NUM_UIDS = 2 ** UID_W;
    localparam int AW       = $clog2(QDEPTH);
    localparam int PW       = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_SEND, S_FREE} state_t;

    // Reject configurations the pointer arithmetic and watchdog cannot handle.
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || WD_CYCLES < 1) begin : g_bad_cfg
        $error("response_order_sched: QDEPTH must be a power of 2 >= 2 and WD_CYCLES >= 1");
    end

    state_t              state;
    logic [UID_W-1:0]    q_mem  [NUM_IDS][QDEPTH];
    logic [PW-1:0]       wr_ptr [NUM_IDS];
    logic [PW-1:0]       rd_ptr [NUM_IDS];
    logic [NUM_UIDS-1:0] arrived;
    logic [NUM_IDS-1:0]  elig_vec;
    logic [ID_WIDTH-1:0] rr_ptr, sel_id, elig_id, scan_id;
    logic [UID_W-1:0]    sel_uid, elig_uid;
    logic                elig_found, push_en, pop_en, clr_en, wd_expire;

    // Ready reflects the registered occupancy only, so a full queue stalls even if it pops this cycle.
    assign issue_ready = (wr_ptr[issue_orig_id] - rd_ptr[issue_orig_id]) != PW'(QDEPTH);
    assign push_en     = issue_valid && issue_ready;
    assign pop_en      = (state == S_ALLOC) && (alloc_gnt || wd_expire);
    assign clr_en      = ((state == S_FREE) && free_ack) || wd_expire;

`ifdef RESP_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign wd_expire = (wd_cnt == WD_W'(WD_CYCLES - 1)) &&
                       (((state == S_ALLOC) && !alloc_gnt) || ((state == S_FREE) && !free_ack));
    assign err_timeout = err_q;

    // Count cycles spent waiting in ALLOC/FREE; IDLE and SEND restart the count.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE || state == S_SEND) wd_cnt <= '0;
        else                                           wd_cnt <= wd_cnt + 1'b1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)            err_q <= 1'b0;
        else if (wd_expire) err_q <= 1'b1;
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Per-ID eligibility: queue non-empty and its head UID already parked.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        elig_vec = '0;
        for (int k = 0; k < NUM_IDS; k++) begin
            elig_vec[k] = (wr_ptr[k] != rd_ptr[k]) && arrived[q_mem[k][rd_ptr[k][AW-1:0]]];
        end
    end

    // Round-robin pick: first eligible ID at or after rr_ptr, wrapping through NUM_IDS-1 -> 0.
    always_comb begin
        elig_found = 1'b0;
        elig_id    = '0;
        elig_uid   = '0;
        scan_id    = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            scan_id = rr_ptr + ID_WIDTH'(i);
            if (!elig_found && elig_vec[scan_id]) begin
                elig_found = 1'b1;
                elig_id    = scan_id;
                elig_uid   = q_mem[scan_id][rd_ptr[scan_id][AW-1:0]];
            end
        end
    end

    // Order-queue storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone decide which entries are valid.
        if (push_en) q_mem[issue_orig_id][wr_ptr[issue_orig_id][AW-1:0]] <= issue_uid;
    end

    // Queue pointers: push and pop on the same ID both take effect, leaving the count unchanged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        for (int k = 0; k < NUM_IDS; k++) begin
            if (rst) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end else begin
                if (push_en && issue_orig_id == ID_WIDTH'(k)) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop_en && sel_id == ID_WIDTH'(k))         rd_ptr[k] <= rd_ptr[k] + 1'b1;
            end
        end
    end

    // Arrived bitmap: the set is written last so it wins over a same-UID clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            arrived <= '0;
        end else begin
            if (clr_en)        arrived[sel_uid]      <= 1'b0;
            if (park_enq_fire) arrived[park_enq_uid] <= 1'b1;
        end
    end

    // Release FSM with registered park handshakes and master-channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            sel_id    <= '0;
            sel_uid   <= '0;
            alloc_req <= 1'b0;
            alloc_uid <= '0;
            free_req  <= 1'b0;
            free_uid  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_resp    <= '0;
            m_id      <= '0;
            m_tag     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (elig_found) begin
                        sel_id    <= elig_id;
                        sel_uid   <= elig_uid;
                        rr_ptr    <= elig_id + ID_WIDTH'(1);
                        alloc_req <= 1'b1;
                        alloc_uid <= elig_uid;
                        state     <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (alloc_gnt) begin
                        alloc_req <= 1'b0;
                        m_valid   <= 1'b1;
                        m_data    <= park_data;
                        m_resp    <= park_resp;
                        m_id      <= park_orig_id;
                        m_tag     <= park_tagid;
                        state     <= S_SEND;
                    end else if (wd_expire) begin
                        alloc_req <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        free_req <= 1'b1;
                        free_uid <= sel_uid;
                        state    <= S_FREE;
                    end
                end
                S_FREE: begin
                    if (free_ack || wd_expire) begin
                        free_req <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_response_order_sched.sv
// tb_response_order_sched
//   Directed bench for response_order_sched. A small park model answers alloc/free
//   requests under bench control; a vector table drives single-response flows and
//   hand-written sequences cover ordering, round-robin, full queue, stalls and reset.
module tb_response_order_sched;

    localparam int UW = 4;
    localparam int WD = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           issue_valid, issue_ready;
    logic [UW-1:0]  issue_uid;
    logic [3:0]     issue_orig_id;
    logic           park_enq_fire;
    logic [UW-1:0]  park_enq_uid;
    logic           alloc_req, alloc_gnt;
    logic [UW-1:0]  alloc_uid;
    logic [255:0]   park_data;
    logic [1:0]     park_resp;
    logic [3:0]     park_orig_id, park_tagid;
    logic           free_req, free_ack;
    logic [UW-1:0]  free_uid;
    logic           m_valid, m_ready;
    logic [255:0]   m_data;
    logic [1:0]     m_resp;
    logic [3:0]     m_id, m_tag;
    logic           err_timeout;

    // Park model: payload store by UID, grant/ack gated by the bench.
    logic [255:0]   pdata [16];
    logic [1:0]     presp [16];
    logic [3:0]     poid  [16];
    logic [3:0]     ptag  [16];
    logic           gnt_en, ack_en;

    assign alloc_gnt    = gnt_en & alloc_req;
    assign free_ack     = ack_en & free_req;
    assign park_data    = pdata[alloc_uid];
    assign park_resp    = presp[alloc_uid];
    assign park_orig_id = poid[alloc_uid];
    assign park_tagid   = ptag[alloc_uid];

    int n_vec = 0;
    int n_err = 0;

    response_order_sched #(.WD_CYCLES(WD)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_uid(issue_uid),
        .issue_orig_id(issue_orig_id),
        .park_enq_fire(park_enq_fire), .park_enq_uid(park_enq_uid),
        .alloc_req(alloc_req), .alloc_uid(alloc_uid), .alloc_gnt(alloc_gnt),
        .park_data(park_data), .park_resp(park_resp), .park_orig_id(park_orig_id),
        .park_tagid(park_tagid),
        .free_req(free_req), .free_uid(free_uid), .free_ack(free_ack),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_resp(m_resp),
        .m_id(m_id), .m_tag(m_tag), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   id;
        logic [UW-1:0] uid;
        logic [255:0] data;
        logic [1:0]   resp;
        logic [3:0]   tag;
        logic [255:0] exp_data;
        logic [1:0]   exp_resp;
        logic [3:0]   exp_id;
        logic [3:0]   exp_tag;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; issue_valid = 1'b0; issue_uid = '0; issue_orig_id = '0;
        park_enq_fire = 1'b0; park_enq_uid = '0; m_ready = 1'b1;
        gnt_en = 1'b1; ack_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [3:0] id, input logic [UW-1:0] uid);
        issue_valid = 1'b1; issue_orig_id = id; issue_uid = uid;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic park(input logic [UW-1:0] uid, input logic [255:0] d, input logic [1:0] r,
                        input logic [3:0] oid, input logic [3:0] tg);
        pdata[uid] = d; presp[uid] = r; poid[uid] = oid; ptag[uid] = tg;
        park_enq_fire = 1'b1; park_enq_uid = uid;
        tick();
        park_enq_fire = 1'b0;
    endtask

    task automatic wait_alloc();
        for (int i = 0; i < 20 && !alloc_req; i++) tick();
        check("alloc_seen", alloc_req, 1);
    endtask

    task automatic wait_mvalid();
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        check("mvalid_seen", m_valid, 1);
    endtask

    task automatic wait_free();
        for (int i = 0; i < 20 && !free_req; i++) tick();
        check("free_seen", free_req, 1);
    endtask

    task automatic release_free();
        ack_en = 1'b1;
        for (int i = 0; i < 20 && free_req; i++) tick();
        check("free_release", free_req, 0);
    endtask

    // Walk one response through ALLOC/SEND/FREE; with hold set, stop while stuck in FREE.
    task automatic serve(input logic [UW-1:0] uid, input logic [255:0] d, input logic [1:0] r,
                         input logic [3:0] oid, input logic [3:0] tg, input bit hold);
        ack_en = !hold;
        m_ready = 1'b1;
        wait_alloc();
        check("alloc_uid", alloc_uid, uid);
        wait_mvalid();
        check("m_data", m_data, d);
        check("m_resp", m_resp, r);
        check("m_id", m_id, oid);
        check("m_tag", m_tag, tg);
        wait_free();
        check("free_uid", free_uid, uid);
        check("alloc_off_in_free", alloc_req, 0);
        if (!hold) begin
            for (int i = 0; i < 20 && free_req; i++) tick();
            check("free_done", free_req, 0);
        end
    endtask

    function automatic logic [255:0] pat(input logic [31:0] seed);
        return {8{seed}};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            pdata[i] = '0; presp[i] = '0; poid[i] = '0; ptag[i] = '0;
        end
        vecs[0] = '{4'd2,  4'd5,  pat(32'hA5A5_0005), 2'd1, 4'd9, pat(32'hA5A5_0005), 2'd1, 4'd2,  4'd9};
        vecs[1] = '{4'd0,  4'd0,  pat(32'h0000_0000), 2'd0, 4'd0, pat(32'h0000_0000), 2'd0, 4'd0,  4'd0};
        vecs[2] = '{4'd15, 4'd15, pat(32'hFFFF_FFFF), 2'd3, 4'd15, pat(32'hFFFF_FFFF), 2'd3, 4'd15, 4'd15};
        vecs[3] = '{4'd7,  4'd10, pat(32'h1234_5678), 2'd2, 4'd6, pat(32'h1234_5678), 2'd2, 4'd7,  4'd6};
        vecs[4] = '{4'd9,  4'd3,  pat(32'hDEAD_BEEF), 2'd1, 4'd3, pat(32'hDEAD_BEEF), 2'd1, 4'd9,  4'd3};

        // Reset state.
        do_reset();
        check("rst_alloc_req", alloc_req, 0);
        check("rst_free_req", free_req, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err", err_timeout, 0);
        check("rst_issue_ready", issue_ready, 1);

        // Single-response flows from the table (vector 0 is the basic id 2 / uid 5 case).
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].id, vecs[v].uid);
            park(vecs[v].uid, vecs[v].data, vecs[v].resp, vecs[v].id, vecs[v].tag);
            serve(vecs[v].uid, vecs[v].exp_data, vecs[v].exp_resp, vecs[v].exp_id, vecs[v].exp_tag, 0);
        end

        // Same-ID order: 7 parked first must wait behind 3.
        do_reset();
        issue(4'd1, 4'd3);
        issue(4'd1, 4'd7);
        park(4'd7, pat(32'h7777_0007), 2'd0, 4'd1, 4'd7);
        for (int i = 0; i < 6; i++) begin
            check("order_hold", alloc_req, 0);
            tick();
        end
        park(4'd3, pat(32'h3333_0003), 2'd2, 4'd1, 4'd3);
        serve(4'd3, pat(32'h3333_0003), 2'd2, 4'd1, 4'd3, 0);
        serve(4'd7, pat(32'h7777_0007), 2'd0, 4'd1, 4'd7, 0);

        // Round-robin: serving id 15 wraps rr_ptr to 0, then 0,1,2; from rr_ptr 3, id 4 beats id 1.
        do_reset();
        issue(4'd15, 4'd15);
        park(4'd15, pat(32'h0F0F_000F), 2'd0, 4'd15, 4'd1);
        serve(4'd15, pat(32'h0F0F_000F), 2'd0, 4'd15, 4'd1, 1);
        issue(4'd2, 4'd12); issue(4'd1, 4'd11); issue(4'd0, 4'd10);
        park(4'd12, pat(32'hC0C0_000C), 2'd1, 4'd2, 4'd2);
        park(4'd11, pat(32'hB0B0_000B), 2'd2, 4'd1, 4'd1);
        park(4'd10, pat(32'hA0A0_000A), 2'd3, 4'd0, 4'd0);
        release_free();
        serve(4'd10, pat(32'hA0A0_000A), 2'd3, 4'd0, 4'd0, 0);
        serve(4'd11, pat(32'hB0B0_000B), 2'd2, 4'd1, 4'd1, 0);
        serve(4'd12, pat(32'hC0C0_000C), 2'd1, 4'd2, 4'd2, 1);
        issue(4'd1, 4'd13); issue(4'd4, 4'd14);
        park(4'd13, pat(32'hD0D0_000D), 2'd0, 4'd1, 4'd13);
        park(4'd14, pat(32'hE0E0_000E), 2'd1, 4'd4, 4'd14);
        release_free();
        serve(4'd14, pat(32'hE0E0_000E), 2'd1, 4'd4, 4'd14, 0);
        serve(4'd13, pat(32'hD0D0_000D), 2'd0, 4'd1, 4'd13, 0);

        // Full queue on id 4: ready drops for id 4 only; a stalled push is dropped.
        do_reset();
        for (int i = 1; i <= 4; i++) issue(4'd4, UW'(i));
        issue_orig_id = 4'd4; #1;
        check("full_ready_id4", issue_ready, 0);
        issue_orig_id = 4'd5; #1;
        check("full_ready_id5", issue_ready, 1);
        issue(4'd4, 4'd9);
        park(4'd1, pat(32'h1111_0001), 2'd0, 4'd4, 4'd1);
        serve(4'd1, pat(32'h1111_0001), 2'd0, 4'd4, 4'd1, 0);
        issue_orig_id = 4'd4; #1;
        check("pop_ready_id4", issue_ready, 1);
        for (int i = 2; i <= 4; i++) begin
            park(UW'(i), pat(32'h2222_0000 + i), 2'd1, 4'd4, 4'(i));
            serve(UW'(i), pat(32'h2222_0000 + i), 2'd1, 4'd4, 4'(i), 0);
        end
        for (int i = 0; i < 4; i++) tick();
        check("full_drained_idle", alloc_req, 0);

        // No grant: ALLOC re-requests; then consumer stall holds m_* stable and delays FREE.
        do_reset();
        gnt_en = 1'b0; m_ready = 1'b0;
        issue(4'd3, 4'd8);
        park(4'd8, pat(32'h8888_0008), 2'd3, 4'd3, 4'd8);
        wait_alloc();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("nogrant_req", alloc_req, 1);
            check("nogrant_uid", alloc_uid, 8);
            check("nogrant_mvalid", m_valid, 0);
        end
        gnt_en = 1'b1;
        wait_mvalid();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, pat(32'h8888_0008));
            check("stall_tag", m_tag, 8);
            check("stall_no_free", free_req, 0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("stall_done_valid", m_valid, 0);
        check("stall_done_free", free_req, 1);
        check("stall_free_uid", free_uid, 8);
        tick();
        check("stall_idle", free_req, 0);

        // Reset mid-SEND drops everything, including a second parked response.
        do_reset();
        m_ready = 1'b0;
        issue(4'd6, 4'd3);
        issue(4'd7, 4'd2);
        park(4'd3, pat(32'h6666_0003), 2'd0, 4'd6, 4'd3);
        park(4'd2, pat(32'h7777_0002), 2'd0, 4'd7, 4'd2);
        wait_mvalid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_mvalid", m_valid, 0);
        check("midrst_alloc", alloc_req, 0);
        check("midrst_free", free_req, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_quiet", alloc_req, 0);
        end

`ifdef RESP_SCHED_WATCHDOG_EN
        // Withheld free_ack: watchdog fires, FSM abandons FREE, reset clears the flag.
        do_reset();
        issue(4'd0, 4'd1);
        park(4'd1, pat(32'h5555_0001), 2'd0, 4'd0, 4'd1);
        serve(4'd1, pat(32'h5555_0001), 2'd0, 4'd0, 4'd1, 1);
        for (int i = 0; i < WD + 4 && free_req; i++) tick();
        check("wd_free_dropped", free_req, 0);
        check("wd_err", err_timeout, 1);
        tick(); tick();
        check("wd_idle", alloc_req, 0);
        do_reset();
        check("wd_rst_err", err_timeout, 0);
        check("wd_rst_free", free_req, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
